// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - shared coin codes, FSM states and counter width
package coin_pkg;

  localparam int CNT_W = $clog2(256);

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_JAM  = 2'd2
  } state_t;

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - per-sensor synchroniser, debounce counter and rising-edge pulse
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sense,
  output logic level,
  output logic rise
);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample; rise is registered alongside it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], sense};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin acceptor top: two debounced sensors, accept/hold-off/jam FSM
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_one,
  input  logic       sense_two,
  input  logic       enable,
  input  logic       jam_clr,
  output logic [1:0] coin,
  output logic       coin_reject,
  output logic       jam
);

  logic lvl_one, lvl_two, ev_one, ev_two;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_one (
    .clk   (clk),
    .rst   (rst),
    .sense (sense_one),
    .level (lvl_one),
    .rise  (ev_one)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_two (
    .clk   (clk),
    .rst   (rst),
    .sense (sense_two),
    .level (lvl_two),
    .rise  (ev_two)
  );

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       coin_n;
  logic             reject_n;
  logic             both, any;

  assign both = ev_one & ev_two;
  assign any  = ev_one | ev_two;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    coin_n   = COIN_NONE;
    reject_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (both) begin
          state_n  = ST_JAM;
          reject_n = 1'b1;
        end else if (any) begin
          if (enable) begin
            coin_n  = ev_one ? COIN_ONE : COIN_TWO;
            state_n = ST_HOLD;
            cnt_n   = CNT_W'(GAP_CYCLES);
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // The final hold-off cycle still rejects; IDLE accepts from the next cycle on
        if (cnt <= CNT_W'(1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
        if (both) begin
          state_n  = ST_JAM;
          cnt_n    = '0;
          reject_n = 1'b1;
        end else if (any) begin
          reject_n = 1'b1;
        end
      end
      ST_JAM: begin
        reject_n = any;
        if (jam_clr && !lvl_one && !lvl_two) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      coin        <= COIN_NONE;
      coin_reject <= 1'b0;
      jam         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      coin        <= coin_n;
      coin_reject <= reject_n;
      jam         <= (state_n == ST_JAM);
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - vector table plus scoreboard bench for coin_acceptor
module tb_coin_acceptor;

  localparam int D   = 4;
  localparam int GAP = 3;

  logic       clk, rst, sense_one, sense_two, enable, jam_clr;
  logic [1:0] coin;
  logic       coin_reject, jam;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .sense_one   (sense_one),
    .sense_two   (sense_two),
    .enable      (enable),
    .jam_clr     (jam_clr),
    .coin        (coin),
    .coin_reject (coin_reject),
    .jam         (jam)
  );

  typedef struct {
    logic [1:0] coin;
    logic       rej;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       ch2;
    logic       en;
    logic [1:0] exp_coin;
    logic       exp_rej;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   outs_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every non-idle output cycle must match the oldest expectation, including its cycle
  always @(negedge clk) begin
    if (rst && (coin != 2'b00 || coin_reject)) begin
      outs_seen++;
      total++;
      if (coin == 2'b11 || (coin != 2'b00 && coin_reject)) begin
        bad++;
        $display("FAIL invariant cyc=%0d coin=%b reject=%b", cyc, coin, coin_reject);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output cyc=%0d coin=%b reject=%b, none required", cyc, coin, coin_reject);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.coin != coin || e.rej != coin_reject || e.cyc != cyc) begin
          bad++;
          $display("FAIL scoreboard got coin=%b reject=%b cyc=%0d, required coin=%b reject=%b cyc=%0d",
                   coin, coin_reject, cyc, e.coin, e.rej, e.cyc);
        end
      end
    end
  end

  task automatic push(input logic [1:0] c, input logic r, input int t);
    exp_t e;
    e.coin = c;
    e.rej  = r;
    e.cyc  = t;
    sb.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b required=%b", name, got, want);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, seen0;

    vecs[0] = '{ch2: 1'b0, en: 1'b1, exp_coin: 2'b01, exp_rej: 1'b0};
    vecs[1] = '{ch2: 1'b1, en: 1'b1, exp_coin: 2'b10, exp_rej: 1'b0};
    vecs[2] = '{ch2: 1'b0, en: 1'b0, exp_coin: 2'b00, exp_rej: 1'b1};
    vecs[3] = '{ch2: 1'b1, en: 1'b0, exp_coin: 2'b00, exp_rej: 1'b1};
    vecs[4] = '{ch2: 1'b1, en: 1'b1, exp_coin: 2'b10, exp_rej: 1'b0};

    rst = 1'b0; sense_one = 1'b0; sense_two = 1'b0; enable = 1'b1; jam_clr = 1'b0;
    ticks(3);
    check("reset_coin", coin, 2'b00);
    check("reset_reject", {1'b0, coin_reject}, 2'b00);
    check("reset_jam", {1'b0, jam}, 2'b00);
    rst = 1'b1;
    ticks(3);

    foreach (vecs[i]) begin
      enable = vecs[i].en;
      if (vecs[i].ch2) sense_two = 1'b1; else sense_one = 1'b1;
      n = cyc + 1;
      push(vecs[i].exp_coin, vecs[i].exp_rej, n + D + 2);
      ticks(D + 4);
      sense_one = 1'b0; sense_two = 1'b0;
      ticks(2 * D + GAP + 6);
    end
    enable = 1'b1;

    // Bounce: short highs never reach D samples; only the final stable press counts
    sense_two = 1'b1; ticks(1);
    sense_two = 1'b0; ticks(2);
    sense_two = 1'b1; ticks(1);
    sense_two = 1'b0; ticks(1);
    sense_two = 1'b1;
    n = cyc + 1;
    push(2'b10, 1'b0, n + D + 2);
    ticks(D + 4);
    sense_two = 1'b0;
    ticks(2 * D + GAP + 6);

    // Hold-off: second channel 2, 3 and 4 edges after the first coin's press
    for (int k = 2; k <= 4; k++) begin
      sense_one = 1'b1;
      n = cyc + 1;
      push(2'b01, 1'b0, n + D + 2);
      ticks(k);
      sense_two = 1'b1;
      n2 = cyc + 1;
      if (k == 4) push(2'b10, 1'b0, n2 + D + 2);
      else        push(2'b00, 1'b1, n2 + D + 2);
      ticks(D + 4);
      sense_one = 1'b0; sense_two = 1'b0;
      ticks(2 * D + GAP + 6);
    end

    // Jam: simultaneous rise, later coin rejected, clear blocked until both released
    sense_one = 1'b1; sense_two = 1'b1;
    n = cyc + 1;
    push(2'b00, 1'b1, n + D + 2);
    wait_until(n + D + 2);
    check("jam_set", {1'b0, jam}, 2'b01);
    sense_two = 1'b0;
    ticks(D + 4);
    sense_two = 1'b1;
    n = cyc + 1;
    push(2'b00, 1'b1, n + D + 2);
    ticks(D + 4);
    sense_two = 1'b0;
    ticks(D + 4);
    jam_clr = 1'b1;
    ticks(2);
    jam_clr = 1'b0;
    check("jam_held_while_pressed", {1'b0, jam}, 2'b01);
    sense_one = 1'b0;
    ticks(D + 4);
    check("jam_before_clr", {1'b0, jam}, 2'b01);
    jam_clr = 1'b1;
    ticks(1);
    jam_clr = 1'b0;
    check("jam_cleared", {1'b0, jam}, 2'b00);
    ticks(4);

    // Glitch of 3 samples is shorter than D and must be invisible
    seen0 = outs_seen;
    sense_one = 1'b1; ticks(3);
    sense_one = 1'b0; ticks(D + 10);
    total++;
    if (outs_seen != seen0) begin
      bad++;
      $display("FAIL glitch outputs=%0d required=0", outs_seen - seen0);
    end

    // Reset on the coin cycle, sensor held through release yields one more coin
    sense_one = 1'b1;
    n = cyc + 1;
    push(2'b01, 1'b0, n + D + 2);
    wait_until(n + D + 2);
    #1 rst = 1'b0;
    #1;
    check("midpulse_coin", coin, 2'b00);
    check("midpulse_reject", {1'b0, coin_reject}, 2'b00);
    check("midpulse_jam", {1'b0, jam}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    n2 = cyc + 1;
    push(2'b01, 1'b0, n2 + D + 2);
    wait_until(n2 + D + 3);
    sense_one = 1'b0;
    ticks(2 * D + GAP + 10);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_outputs pending=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
